// File: rtl/sram_rc_param_if.sv
// Bus bundle for sram_rc_param: access request, clear request and status.
// The master drives requests, the slave (the SRAM) returns data and status.
interface sram_rc_param_if #(
  parameter int AW = 7,
  parameter int DW = 1
);
  logic          we_n;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] wmask;
  logic          clr_n;
  logic [DW-1:0] dout;
  logic          busy;
  logic          clr_done;
  logic          addr_err;

  modport master (
    output we_n, addr, din, wmask, clr_n,
    input  dout, busy, clr_done, addr_err
  );

  modport slave (
    input  we_n, addr, din, wmask, clr_n,
    output dout, busy, clr_done, addr_err
  );
endinterface

// File: rtl/sram_rc_param.sv
// Parametrised single-port bit-cell SRAM of ROWS x COLS cells, DW bits each,
// with per-bit write mask, selectable read-during-write ordering and a
// row-at-a-time clear sequencer.
module sram_rc_param #(
  parameter int ROWS     = 16,
  parameter int COLS     = 8,
  parameter int DW       = 1,
  parameter int RDW_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  sram_rc_param_if.slave    bus
);

  localparam int RAW = ($clog2(ROWS) > 1) ? $clog2(ROWS) : 1;
  localparam int CAW = $clog2(COLS);
  localparam int AW  = RAW + CAW;

  // One extra bit so that ROWS itself is representable when ROWS is a power of two.
  localparam logic [RAW:0]   ROW_LIMIT = (RAW + 1)'(ROWS);
  localparam logic [RAW-1:0] LAST_ROW  = RAW'(ROWS - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [RAW-1:0] cnt;
  logic [RAW-1:0] cnt_nx;
  logic           row_wipe;
  logic [RAW-1:0] wipe_row;

  logic [DW-1:0]  mem [ROWS][COLS];

  logic [RAW-1:0] row;
  logic [CAW-1:0] col;
  logic           row_ok;
  logic           clr_req;
  logic           access;
  logic           do_write;
  logic [DW-1:0]  old_data;
  logic [DW-1:0]  merged;
  logic [DW-1:0]  rd_data;

  logic [DW-1:0]  dout_q;
  logic           clr_done_q;
  logic           addr_err_q;

  assign row      = bus.addr[AW-1:CAW];
  assign col      = bus.addr[CAW-1:0];
  assign row_ok   = ({1'b0, row} < ROW_LIMIT);
  assign clr_req  = (state == IDLE) && !bus.clr_n;
  // A normal access only happens in IDLE when no clear is being requested;
  // a clear request on the same edge wins over any read or write.
  assign access   = (state == IDLE) && bus.clr_n;
  assign do_write = access && !bus.we_n && row_ok;

  // Row 0 is wiped on the request edge itself, so busy also covers the
  // request cycle and the whole clear spans exactly ROWS cycles.
  assign bus.busy     = (state == CLEAR) || clr_req;
  assign bus.dout     = dout_q;
  assign bus.clr_done = clr_done_q;
  assign bus.addr_err = addr_err_q;

  // Cell lookup and mask merge; rows beyond ROWS read as zero and alias nothing.
  always_comb begin
    old_data = '0;
    if (row_ok) begin
      old_data = mem[row][col];
    end
    merged  = (old_data & ~bus.wmask) | (bus.din & bus.wmask);
    rd_data = old_data;
    if (!row_ok) begin
      rd_data = '0;
    end else if ((RDW_MODE == 1) && !bus.we_n) begin
      rd_data = merged;
    end
  end

  // Clear sequencer next-state: request edge wipes row 0, then one row per edge.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    row_wipe = 1'b0;
    wipe_row = '0;
    case (state)
      IDLE: begin
        if (!bus.clr_n) begin
          row_wipe = 1'b1;
          wipe_row = '0;
          cnt_nx   = RAW'(1);
          state_nx = CLEAR;
        end
      end
      CLEAR: begin
        row_wipe = 1'b1;
        wipe_row = cnt;
        if (cnt == LAST_ROW) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Sequencer state register; reset aborts any clear in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Cell array: row wipes take priority, writes only happen on a valid IDLE access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          mem[r][c] <= '0;
        end
      end
    end else if (row_wipe) begin
      for (int c = 0; c < COLS; c++) begin
        mem[wipe_row][c] <= '0;
      end
    end else if (do_write) begin
      mem[row][col] <= merged;
    end
  end

  // Registered read data and status; dout holds whenever no access is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q     <= '0;
      clr_done_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      clr_done_q <= (state == CLEAR) && (cnt == LAST_ROW);
      addr_err_q <= access && !row_ok;
      if (access) begin
        dout_q <= rd_data;
      end
    end
  end

endmodule
